// File: rtl/model_write_heads_scheduler.sv
// rtl/model_write_heads_scheduler.sv - sequences the six DNC write-head accelerators
// GA, GW, BETA get a scalar operand; E, K, V get W streamed elements.
module model_write_heads_scheduler #(
  parameter int DATA_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  output logic                 DONE,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic [DATA_SIZE-1:0] GA_IN,
  input  logic [DATA_SIZE-1:0] GW_IN,
  input  logic [DATA_SIZE-1:0] BETA_IN,
  output logic                 DATA_IN_REQ,
  output logic [2:0]           CURRENT_UNIT,
  input  logic                 DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic [5:0]           UNIT_START,
  input  logic [5:0]           UNIT_READY,
  output logic [5:0]           UNIT_IN_ENABLE,
  output logic [DATA_SIZE-1:0] UNIT_SIZE_W_OUT,
  output logic [DATA_SIZE-1:0] UNIT_DATA_OUT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCALAR_START,
    S_SCALAR_WAIT,
    S_VECTOR_START,
    S_FEED,
    S_VECTOR_WAIT,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [2:0]           unit_idx, unit_idx_nxt;
  logic [DATA_SIZE-1:0] w_q, ga_q, gw_q, beta_q;
  logic [DATA_SIZE-1:0] elem_cnt, data_q, size_w_q;
  logic [5:0]           in_en_q;
  logic [5:0]           unit_onehot;
  logic                 unit_rdy, accept, last_elem;

  assign unit_onehot = 6'b000001 << unit_idx;
  assign unit_rdy    = |(UNIT_READY & unit_onehot);
  assign accept      = (state == S_FEED) && DATA_IN_ENABLE;
  // W is nonzero whenever FEED is reached, so W-1 never underflows here
  assign last_elem   = accept && (elem_cnt == (w_q - DATA_SIZE'(1)));

  always_comb begin
    state_nxt    = state;
    unit_idx_nxt = unit_idx;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_nxt    = S_SCALAR_START;
          unit_idx_nxt = 3'd0;
        end
      end
      S_SCALAR_START: state_nxt = S_SCALAR_WAIT;
      S_SCALAR_WAIT: begin
        if (unit_rdy) begin
          if (unit_idx != 3'd2) begin
            unit_idx_nxt = unit_idx + 3'd1;
            state_nxt    = S_SCALAR_START;
          end else begin
            unit_idx_nxt = 3'd3;
            state_nxt    = (w_q != '0) ? S_VECTOR_START : S_DONE;
          end
        end
      end
      S_VECTOR_START: state_nxt = S_FEED;
      S_FEED: begin
        if (last_elem) state_nxt = S_VECTOR_WAIT;
      end
      S_VECTOR_WAIT: begin
        if (unit_rdy) begin
          if (unit_idx != 3'd5) begin
            unit_idx_nxt = unit_idx + 3'd1;
            state_nxt    = S_VECTOR_START;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_IDLE;
      unit_idx <= 3'd0;
      w_q      <= '0;
      ga_q     <= '0;
      gw_q     <= '0;
      beta_q   <= '0;
      elem_cnt <= '0;
      data_q   <= '0;
      size_w_q <= '0;
      in_en_q  <= '0;
    end else begin
      state    <= state_nxt;
      unit_idx <= unit_idx_nxt;
      in_en_q  <= accept ? unit_onehot : 6'b0;
      if (state == S_IDLE && START) begin
        w_q    <= SIZE_W_IN;
        ga_q   <= GA_IN;
        gw_q   <= GW_IN;
        beta_q <= BETA_IN;
        data_q <= GA_IN;
      end
      // next scalar operand is on the bus by the time its start pulse fires
      if (state == S_SCALAR_WAIT && unit_rdy && unit_idx != 3'd2)
        data_q <= (unit_idx == 3'd0) ? gw_q : beta_q;
      if (state_nxt == S_VECTOR_START)
        size_w_q <= w_q;
      if (state == S_VECTOR_START)
        elem_cnt <= '0;
      if (accept) begin
        elem_cnt <= elem_cnt + DATA_SIZE'(1);
        data_q   <= DATA_IN;
      end
    end
  end

  assign READY           = (state == S_IDLE);
  assign DONE            = (state == S_DONE);
  assign DATA_IN_REQ     = (state == S_FEED);
  assign CURRENT_UNIT    = (state == S_IDLE) ? 3'd7 : unit_idx;
  assign UNIT_START      = (state == S_SCALAR_START || state == S_VECTOR_START) ? unit_onehot : 6'b0;
  assign UNIT_IN_ENABLE  = in_en_q;
  assign UNIT_SIZE_W_OUT = size_w_q;
  assign UNIT_DATA_OUT   = data_q;

endmodule

// File: tb/tb_model_write_heads_scheduler.sv
// tb/tb_model_write_heads_scheduler.sv - directed bench for model_write_heads_scheduler
module tb_model_write_heads_scheduler;
  localparam int DS = 64;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START = 1'b0;
  logic          READY, DONE, DATA_IN_REQ;
  logic [DS-1:0] SIZE_W_IN = '0, GA_IN = '0, GW_IN = '0, BETA_IN = '0, DATA_IN = '0;
  logic [2:0]    CURRENT_UNIT;
  logic          DATA_IN_ENABLE = 1'b0;
  logic [5:0]    UNIT_START, UNIT_IN_ENABLE;
  logic [5:0]    UNIT_READY = 6'h3f;
  logic [DS-1:0] UNIT_SIZE_W_OUT, UNIT_DATA_OUT;

  model_write_heads_scheduler #(.DATA_SIZE(DS)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .DONE(DONE),
    .SIZE_W_IN(SIZE_W_IN), .GA_IN(GA_IN), .GW_IN(GW_IN), .BETA_IN(BETA_IN),
    .DATA_IN_REQ(DATA_IN_REQ), .CURRENT_UNIT(CURRENT_UNIT),
    .DATA_IN_ENABLE(DATA_IN_ENABLE), .DATA_IN(DATA_IN),
    .UNIT_START(UNIT_START), .UNIT_READY(UNIT_READY), .UNIT_IN_ENABLE(UNIT_IN_ENABLE),
    .UNIT_SIZE_W_OUT(UNIT_SIZE_W_OUT), .UNIT_DATA_OUT(UNIT_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;

  int          start_k[6];
  int          ie_cnt[6];
  logic [63:0] ie_first[6], ie_last[6], sd[6], wd[6], sw_out[6];
  int          done_k, done_cnt, req_cyc, lat_err, multi_err, stall_err, idle_err;
  bit          post_ok, aborted;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outs(input string pfx);
    check({pfx, "_ready"}, 64'(READY), 64'd1);
    check({pfx, "_done"}, 64'(DONE), 64'd0);
    check({pfx, "_req"}, 64'(DATA_IN_REQ), 64'd0);
    check({pfx, "_cur_unit"}, 64'(CURRENT_UNIT), 64'd7);
    check({pfx, "_unit_start"}, 64'(UNIT_START), 64'd0);
    check({pfx, "_in_en"}, 64'(UNIT_IN_ENABLE), 64'd0);
    check({pfx, "_data_out"}, UNIT_DATA_OUT, 64'd0);
    check({pfx, "_size_w_out"}, UNIT_SIZE_W_OUT, 64'd0);
  endtask

  // en_mode 1: per vector unit the enable pattern is 1,0,1,0,...
  task automatic run_seq(input logic [63:0] w, input logic [63:0] ga, input logic [63:0] gw,
                         input logic [63:0] beta, input int en_mode, input int stall_u,
                         input int busy_k, input bit abort_u4);
    logic [63:0] next_elem, pend_d;
    bit          pend_v, en;
    int          pend_u, cur_vec, feed_pos;
    for (int i = 0; i < 6; i++) begin
      start_k[i] = -1; ie_cnt[i] = 0; ie_first[i] = '0; ie_last[i] = '0;
      sd[i] = '0; wd[i] = '0; sw_out[i] = '0;
    end
    done_k = -1; done_cnt = 0; req_cyc = 0; lat_err = 0; multi_err = 0; stall_err = 0;
    post_ok = 1'b0; aborted = 1'b0;
    next_elem = 64'd1; pend_v = 1'b0; pend_u = 0; pend_d = '0; cur_vec = 3; feed_pos = 0;
    SIZE_W_IN = w; GA_IN = ga; GW_IN = gw; BETA_IN = beta;
    START = 1'b1; DATA_IN_ENABLE = 1'b1; UNIT_READY = 6'h3f;
    @(posedge CLK);
    for (int k = 1; k < 200; k++) begin
      @(negedge CLK);
      if (UNIT_START != 6'b0) begin
        if (!$onehot(UNIT_START)) multi_err++;
        for (int i = 0; i < 6; i++)
          if (UNIT_START[i]) begin
            start_k[i] = k; sd[i] = UNIT_DATA_OUT; sw_out[i] = UNIT_SIZE_W_OUT;
            if (i >= 3) cur_vec = i;
          end
        feed_pos = 0;
      end
      for (int i = 0; i < 3; i++)
        if (start_k[i] > 0 && start_k[i] == k - 1) wd[i] = UNIT_DATA_OUT;
      if (UNIT_IN_ENABLE != 6'b0) begin
        if (!$onehot(UNIT_IN_ENABLE)) multi_err++;
        for (int i = 0; i < 6; i++)
          if (UNIT_IN_ENABLE[i]) begin
            if (ie_cnt[i] == 0) ie_first[i] = UNIT_DATA_OUT;
            ie_last[i] = UNIT_DATA_OUT;
            ie_cnt[i]++;
          end
      end
      if (pend_v != (UNIT_IN_ENABLE != 6'b0)) lat_err++;
      else if (pend_v && (UNIT_IN_ENABLE != (6'b000001 << pend_u) || UNIT_DATA_OUT != pend_d)) lat_err++;
      if (stall_u >= 0 && start_k[stall_u] > 0 && k > start_k[stall_u] && k <= start_k[stall_u] + 11)
        if (CURRENT_UNIT != 3'(stall_u) || UNIT_START != 6'b0) stall_err++;
      if (DONE) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (done_k > 0 && k == done_k + 1) post_ok = READY && (CURRENT_UNIT == 3'd7) && !DONE;
      if (DATA_IN_REQ) req_cyc++;
      if (abort_u4 && CURRENT_UNIT == 3'd4 && DATA_IN_REQ && feed_pos == 2) begin
        RST = 1'b0;
        aborted = 1'b1;
        break;
      end
      START = (k == busy_k);
      if (k == busy_k) begin
        GA_IN = 64'hEE;
        SIZE_W_IN = 64'd7;
      end
      en = (en_mode == 1 && DATA_IN_REQ) ? (feed_pos % 2 == 0) : 1'b1;
      DATA_IN_ENABLE = en;
      DATA_IN = next_elem;
      UNIT_READY = 6'h3f;
      if (stall_u >= 0 && start_k[stall_u] > 0 && k <= start_k[stall_u] + 10)
        UNIT_READY[stall_u] = 1'b0;
      pend_v = DATA_IN_REQ && en;
      pend_u = cur_vec;
      pend_d = next_elem;
      if (pend_v) next_elem++;
      if (DATA_IN_REQ) feed_pos++;
      if (done_k > 0 && k >= done_k + 3) break;
    end
    START = 1'b0;
  endtask

  int exp_start1[6] = '{1, 3, 5, 7, 13, 19};
  int exp_start2[6] = '{1, 3, 5, 7, 14, 21};

  initial begin
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset_outs("rst");
    RST = 1'b1;
    @(negedge CLK);

    // full sequence, W=4, unbroken stream
    run_seq(64'd4, 64'h11, 64'h22, 64'h33, 0, -1, -1, 1'b0);
    for (int i = 0; i < 6; i++) check($sformatf("t1_start_k%0d", i), 64'(start_k[i]), 64'(exp_start1[i]));
    check("t1_sd0", sd[0], 64'h11);
    check("t1_sd1", sd[1], 64'h22);
    check("t1_sd2", sd[2], 64'h33);
    check("t1_wd1", wd[1], 64'h22);
    check("t1_done_k", 64'(done_k), 64'd25);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    for (int i = 3; i < 6; i++) begin
      check($sformatf("t1_ie_cnt%0d", i), 64'(ie_cnt[i]), 64'd4);
      check($sformatf("t1_ie_first%0d", i), ie_first[i], 64'((i - 3) * 4 + 1));
      check($sformatf("t1_ie_last%0d", i), ie_last[i], 64'((i - 3) * 4 + 4));
      check($sformatf("t1_sw_out%0d", i), sw_out[i], 64'd4);
    end
    check("t1_lat_err", 64'(lat_err), 64'd0);
    check("t1_multi_err", 64'(multi_err), 64'd0);
    check("t1_post_idle", 64'(post_ok), 64'd1);

    // W=3 with bubbles 1,0,1,0,1
    run_seq(64'd3, 64'h1, 64'h2, 64'h3, 1, -1, -1, 1'b0);
    for (int i = 0; i < 6; i++) check($sformatf("t2_start_k%0d", i), 64'(start_k[i]), 64'(exp_start2[i]));
    check("t2_done_k", 64'(done_k), 64'd28);
    check("t2_req_cyc", 64'(req_cyc), 64'd15);
    for (int i = 3; i < 6; i++) begin
      check($sformatf("t2_ie_cnt%0d", i), 64'(ie_cnt[i]), 64'd3);
      check($sformatf("t2_ie_first%0d", i), ie_first[i], 64'((i - 3) * 3 + 1));
      check($sformatf("t2_ie_last%0d", i), ie_last[i], 64'((i - 3) * 3 + 3));
    end
    check("t2_lat_err", 64'(lat_err), 64'd0);

    // unit 1 ready held low for 10 cycles
    run_seq(64'd2, 64'h4, 64'h5, 64'h6, 0, 1, -1, 1'b0);
    check("t3_start_k1", 64'(start_k[1]), 64'd3);
    check("t3_start_k2", 64'(start_k[2]), 64'd15);
    check("t3_start_k3", 64'(start_k[3]), 64'd17);
    check("t3_start_k5", 64'(start_k[5]), 64'd25);
    check("t3_stall_err", 64'(stall_err), 64'd0);
    check("t3_done_k", 64'(done_k), 64'd29);

    // W=0 skips the vector units
    run_seq(64'd0, 64'h7, 64'h8, 64'h9, 0, -1, -1, 1'b0);
    check("t4_start_k2", 64'(start_k[2]), 64'd5);
    check("t4_start_k3", 64'(start_k[3]), -64'sd1);
    check("t4_start_k5", 64'(start_k[5]), -64'sd1);
    check("t4_req_cyc", 64'(req_cyc), 64'd0);
    check("t4_ie_total", 64'(ie_cnt[3] + ie_cnt[4] + ie_cnt[5]), 64'd0);
    check("t4_done_k", 64'(done_k), 64'd7);

    // START while busy is ignored
    run_seq(64'd2, 64'h5A, 64'h6B, 64'h7C, 0, -1, 1, 1'b0);
    check("t5_wd0", wd[0], 64'h5A);
    check("t5_sd1", sd[1], 64'h6B);
    check("t5_sw_out3", sw_out[3], 64'd2);
    check("t5_sw_out5", sw_out[5], 64'd2);
    check("t5_done_k", 64'(done_k), 64'd19);
    check("t5_done_cnt", 64'(done_cnt), 64'd1);

    // reset during FEED of unit 4, then a clean rerun
    run_seq(64'd4, 64'h1, 64'h2, 64'h3, 0, -1, -1, 1'b1);
    check("t6_aborted", 64'(aborted), 64'd1);
    @(posedge CLK);
    @(negedge CLK);
    check_reset_outs("t6_abort");
    RST = 1'b1;
    idle_err = 0;
    repeat (4) begin
      @(negedge CLK);
      if (UNIT_START != 6'b0 || UNIT_IN_ENABLE != 6'b0 || DATA_IN_REQ || !READY) idle_err++;
    end
    check("t6_idle_err", 64'(idle_err), 64'd0);
    run_seq(64'd4, 64'h11, 64'h22, 64'h33, 0, -1, -1, 1'b0);
    check("t6_done_k", 64'(done_k), 64'd25);
    check("t6_start_k4", 64'(start_k[4]), 64'd13);
    check("t6_ie_first3", ie_first[3], 64'd1);
    check("t6_ie_last5", ie_last[5], 64'd12);
    check("t6_lat_err", 64'(lat_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
